// File: rtl/cv32e40p_mult_wb_buffer.sv
// Result FIFO between the multiplier/MAC unit and the writeback port.
// Holds completed results with their destination address and flags RAW hazards on pending writes.
module cv32e40p_mult_wb_buffer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [31:0]                in_result_i,
    input  logic [5:0]                 in_waddr_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [31:0]                wb_result_o,
    output logic [5:0]                 wb_waddr_o,
    input  logic                       flush_i,
    input  logic [5:0]                 hazard_raddr_a_i,
    input  logic [5:0]                 hazard_raddr_b_i,
    output logic                       hazard_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // A source address conflicts with a write only if it is a real register (x0 never stalls)
    function automatic logic addr_hit(input logic [5:0] raddr,
                                      input logic [5:0] waddr,
                                      input logic       valid);
        return valid && (raddr != 6'd0) && (raddr == waddr);
    endfunction

    logic [31:0]    result_mem_r [DEPTH];
    logic [5:0]     waddr_mem_r  [DEPTH];
    logic [AW-1:0]  wptr_r;
    logic [AW-1:0]  rptr_r;
    logic [CW-1:0]  cnt_r;

    logic           push_s;
    logic           pop_s;
    logic           in_hs_s;
    logic [DEPTH-1:0] entry_valid_s;
    logic           hazard_s;

    assign in_ready_o  = (cnt_r != FULL_CNT);
    assign wb_valid_o  = (cnt_r != {CW{1'b0}});
    assign wb_result_o = result_mem_r[rptr_r];
    assign wb_waddr_o  = waddr_mem_r[rptr_r];
    assign count_o     = cnt_r;
    assign hazard_o    = hazard_s;

    assign in_hs_s = in_valid_i & in_ready_o;
    assign push_s  = in_hs_s & ~flush_i;
    assign pop_s   = wb_valid_o & wb_ready_i & ~flush_i;

    // Slot i is occupied when its distance from the read pointer is below the occupancy
    always_comb begin
        entry_valid_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid_s[i] = ({1'b0, AW'(AW'(i) - rptr_r)} < cnt_r);
        end
    end

    // Hazard: match against every pending entry and the result being accepted this cycle
    always_comb begin
        hazard_s = 1'b0;
        if (flush_i) begin
            hazard_s = 1'b0;
        end else begin
            hazard_s = addr_hit(hazard_raddr_a_i, in_waddr_i, in_hs_s) |
                       addr_hit(hazard_raddr_b_i, in_waddr_i, in_hs_s);
            for (int i = 0; i < DEPTH; i++) begin
                hazard_s = hazard_s |
                           addr_hit(hazard_raddr_a_i, waddr_mem_r[i], entry_valid_s[i]) |
                           addr_hit(hazard_raddr_b_i, waddr_mem_r[i], entry_valid_s[i]);
            end
        end
    end

    // Pointer, occupancy and storage update; flush leaves entry data untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cnt_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                result_mem_r[i] <= 32'd0;
                waddr_mem_r[i]  <= 6'd0;
            end
        end else if (flush_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (push_s) begin
                result_mem_r[wptr_r] <= in_result_i;
                waddr_mem_r[wptr_r]  <= in_waddr_i;
                wptr_r               <= wptr_r + AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_mult_wb_buffer.sv
// Self-checking bench for cv32e40p_mult_wb_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_cv32e40p_mult_wb_buffer;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [31:0]   in_result_i;
    logic [5:0]    in_waddr_i;
    logic          wb_valid_o;
    logic          wb_ready_i;
    logic [31:0]   wb_result_o;
    logic [5:0]    wb_waddr_o;
    logic          flush_i;
    logic [5:0]    hazard_raddr_a_i;
    logic [5:0]    hazard_raddr_b_i;
    logic          hazard_o;
    logic [CW-1:0] count_o;

    cv32e40p_mult_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_result_i      (in_result_i),
        .in_waddr_i       (in_waddr_i),
        .wb_valid_o       (wb_valid_o),
        .wb_ready_i       (wb_ready_i),
        .wb_result_o      (wb_result_o),
        .wb_waddr_o       (wb_waddr_o),
        .flush_i          (flush_i),
        .hazard_raddr_a_i (hazard_raddr_a_i),
        .hazard_raddr_b_i (hazard_raddr_b_i),
        .hazard_o         (hazard_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  waddr;
        logic [31:0] result;
    } entry_t;

    entry_t q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hazard(input logic [5:0] ra, input logic [5:0] rb,
                                          input logic iv, input logic [5:0] wa,
                                          input logic fl);
        logic h;
        h = 1'b0;
        if (!fl) begin
            foreach (q[k]) begin
                if (ra != 6'd0 && q[k].waddr == ra) h = 1'b1;
                if (rb != 6'd0 && q[k].waddr == rb) h = 1'b1;
            end
            if (iv && q.size() != DEPTH) begin
                if (ra != 6'd0 && wa == ra) h = 1'b1;
                if (rb != 6'd0 && wa == rb) h = 1'b1;
            end
        end
        return h;
    endfunction

    // One clock cycle: drive inputs, check every output against the model, advance the model.
    task automatic step(input logic iv, input logic [31:0] res, input logic [5:0] wa,
                        input logic wr, input logic fl,
                        input logic [5:0] ra, input logic [5:0] rb);
        logic rdy_e, val_e, do_push, do_pop;
        @(negedge clk);
        in_valid_i = iv; in_result_i = res; in_waddr_i = wa;
        wb_ready_i = wr; flush_i = fl;
        hazard_raddr_a_i = ra; hazard_raddr_b_i = rb;
        #1;
        rdy_e = (q.size() != DEPTH);
        val_e = (q.size() != 0);
        check_eq("in_ready", in_ready_o, rdy_e);
        check_eq("wb_valid", wb_valid_o, val_e);
        check_eq("count", count_o, q.size());
        check_eq("hazard", hazard_o, model_hazard(ra, rb, iv, wa, fl));
        if (val_e) begin
            check_eq("wb_result", wb_result_o, q[0].result);
            check_eq("wb_waddr", wb_waddr_o, q[0].waddr);
        end
        do_push = iv && rdy_e && !fl;
        do_pop  = val_e && wr && !fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{waddr: wa, result: res});
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid_i = 1'b0; in_result_i = 32'd0; in_waddr_i = 6'd0;
        wb_ready_i = 1'b0; flush_i = 1'b0;
        hazard_raddr_a_i = 6'd0; hazard_raddr_b_i = 6'd0;
        #12;
        check_eq("rst_wb_valid", wb_valid_o, 1'b0);
        check_eq("rst_wb_result", wb_result_o, 32'd0);
        check_eq("rst_wb_waddr", wb_waddr_o, 6'd0);
        check_eq("rst_in_ready", in_ready_o, 1'b1);
        check_eq("rst_count", count_o, 0);
        check_eq("rst_hazard", hazard_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single result, one-cycle latency, then drains
        step(1'b1, 32'h6, 6'd5, 1'b1, 1'b0, 6'd0, 6'd0);
        check_eq("single_valid", wb_valid_o, 1'b1);
        check_eq("single_result", wb_result_o, 32'h6);
        check_eq("single_waddr", wb_waddr_o, 6'd5);
        step(1'b0, 32'h0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0);
        check_eq("single_drained", wb_valid_o, 1'b0);
        check_eq("single_count", count_o, 0);

        // Fill and stall
        step(1'b1, 32'h11, 6'd1, 1'b0, 1'b0, 6'd0, 6'd0);
        step(1'b1, 32'h22, 6'd2, 1'b0, 1'b0, 6'd0, 6'd0);
        check_eq("fill_count", count_o, 2);
        check_eq("fill_ready", in_ready_o, 1'b0);
        step(1'b1, 32'h33, 6'd3, 1'b0, 1'b0, 6'd0, 6'd0);
        check_eq("fill_reject_count", count_o, 2);
        check_eq("fill_head", wb_result_o, 32'h11);
        step(1'b0, 32'h0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0);
        check_eq("fill_second", wb_result_o, 32'h22);
        step(1'b0, 32'h0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0);
        check_eq("fill_empty", wb_valid_o, 1'b0);

        // Wrap-around stream
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'(i), 6'd4, 1'b1, 1'b0, 6'd0, 6'd0);
            check_eq("wrap_data", wb_result_o, 32'(i));
            check_eq("wrap_cnt_le1", (count_o <= 1), 1'b1);
        end
        step(1'b0, 32'h0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0);

        // Hazards: x0 pending, full buffer blocks incoming match, then pending 7
        step(1'b1, 32'hA0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0);
        step(1'b1, 32'hA7, 6'd7, 1'b0, 1'b0, 6'd0, 6'd0);
        step(1'b1, 32'hA9, 6'd9, 1'b0, 1'b0, 6'd0, 6'd9);
        check_eq("hz_full_nomatch", hazard_o, 1'b0);
        step(1'b0, 32'h0, 6'd0, 1'b0, 1'b0, 6'd7, 6'd0);
        check_eq("hz_pending7", hazard_o, 1'b1);
        step(1'b0, 32'h0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0);
        step(1'b1, 32'hA9, 6'd9, 1'b0, 1'b0, 6'd0, 6'd9);

        // Flush with a concurrent push, then fresh data
        step(1'b1, 32'hEE, 6'd3, 1'b1, 1'b1, 6'd9, 6'd0);
        check_eq("flush_count", count_o, 0);
        check_eq("flush_valid", wb_valid_o, 1'b0);
        step(1'b1, 32'hAB, 6'd8, 1'b0, 1'b0, 6'd0, 6'd0);
        check_eq("post_flush_data", wb_result_o, 32'hAB);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, 6'($urandom_range(0, 7)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
        end

        // Asynchronous reset with one entry pending
        step(1'b0, 32'h0, 6'd0, 1'b1, 1'b1, 6'd0, 6'd0);
        step(1'b1, 32'h55, 6'd6, 1'b0, 1'b0, 6'd0, 6'd0);
        check_eq("pre_areset_valid", wb_valid_o, 1'b1);
        in_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("areset_valid", wb_valid_o, 1'b0);
        check_eq("areset_ready", in_ready_o, 1'b1);
        check_eq("areset_count", count_o, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
